// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: one requester port of the shared-RAM arbiter
interface ram_arbiter_if;
  logic req;
  logic rw;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic gnt;
  logic done;
  logic [7:0] rdata;
  modport master(output req, rw, addr, wdata, input gnt, done, rdata);
  modport slave(input req, rw, addr, wdata, output gnt, done, rdata);
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin core/io arbiter running setup, chip-select and done phases on a shared RAM
module ram_arbiter #(
  parameter int CS_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  ram_arbiter_if.slave     core,
  ram_arbiter_if.slave     io,
  output logic             ram_cs,
  output logic             ram_rw,
  output logic [7:0]       ram_addr,
  output logic [7:0]       ram_data_in,
  input  logic [7:0]       ram_data_out,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  state_t state, state_nx;
  logic last;
  logic win_io;
  logic start;
  logic last_acc;
  logic act;
  logic [3:0] cnt;
  logic rw_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic [7:0] core_rdata;
  logic [7:0] io_rdata;
  // last = 1 means io was served most recently, so core wins a tie
  assign win_io = io.req & (~core.req | ~last);
  assign start = state == IDLE && (core.req || io.req);
  assign last_acc = state == ACCESS && cnt == 4'(CS_CYCLES - 1);
  assign act = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE   ? (start ? SETUP : IDLE) :
               state == SETUP  ? ACCESS :
               state == ACCESS ? (last_acc ? DONE : ACCESS) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last       <= 1'b1;
      cnt        <= 4'd0;
      rw_q       <= 1'b0;
      addr_q     <= 8'd0;
      wdata_q    <= 8'd0;
      core_rdata <= 8'd0;
      io_rdata   <= 8'd0;
    end else begin
      if (start) begin
        last    <= win_io;
        rw_q    <= win_io ? io.rw : core.rw;
        addr_q  <= win_io ? io.addr : core.addr;
        wdata_q <= win_io ? io.wdata : core.wdata;
      end
      cnt <= state == ACCESS ? cnt + 4'd1 : 4'd0;
      if (last_acc && rw_q && last) io_rdata <= ram_data_out;
      if (last_acc && rw_q && !last) core_rdata <= ram_data_out;
    end
  assign ram_cs      = state == ACCESS;
  assign ram_rw      = act & rw_q;
  assign ram_addr    = act ? addr_q : 8'd0;
  assign ram_data_in = act ? wdata_q : 8'd0;
  assign busy        = act;
  assign core.gnt    = act & ~last;
  assign io.gnt      = act & last;
  assign core.done   = state == DONE && !last;
  assign io.done     = state == DONE && last;
  assign core.rdata  = core_rdata;
  assign io.rdata    = io_rdata;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vectors and multi-cycle sequences for ram_arbiter
module tb_ram_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  ram_arbiter_if core(), io(), c1(), i1(), c15(), i15();
  logic ram_cs, ram_rw, busy;
  logic [7:0] ram_addr, ram_data_in, ram_data_out;
  logic cs1, rw1, busy1, cs15, rw15, busy15;
  logic [7:0] a1, d1, a15, d15;
  logic [7:0] mem [256];
  int checks = 0;
  int errors = 0;
  ram_arbiter #(.CS_CYCLES(2)) dut (.clk(clk), .rst_n(rst_n), .core(core), .io(io),
    .ram_cs(ram_cs), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out), .busy(busy));
  ram_arbiter #(.CS_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .core(c1), .io(i1),
    .ram_cs(cs1), .ram_rw(rw1), .ram_addr(a1), .ram_data_in(d1),
    .ram_data_out(8'hC3), .busy(busy1));
  ram_arbiter #(.CS_CYCLES(15)) dut15 (.clk(clk), .rst_n(rst_n), .core(c15), .io(i15),
    .ram_cs(cs15), .ram_rw(rw15), .ram_addr(a15), .ram_data_in(d15),
    .ram_data_out(8'h9E), .busy(busy15));
  assign ram_data_out = mem[ram_addr];
  always @(posedge clk) if (ram_cs && !ram_rw) mem[ram_addr] = ram_data_in;
  typedef struct {
    logic port;
    logic rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_core;
    logic [7:0] exp_io;
  } vec_t;
  vec_t v [6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic xact(input logic port, input logic rw, input logic [7:0] addr, input logic [7:0] wdata,
                      output int lat, output int csw, output logic ok);
    @(negedge clk);
    if (port) begin io.req = 1; io.rw = rw; io.addr = addr; io.wdata = wdata; end
    else begin core.req = 1; core.rw = rw; core.addr = addr; core.wdata = wdata; end
    lat = 0;
    csw = 0;
    ok = 1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      lat++;
      if (ram_cs) csw++;
      if ((core.gnt && io.gnt) || (core.done && io.done)) ok = 0;
      if (lat == 1 && (port ? !io.gnt : !core.gnt)) ok = 0;
      if (port ? io.done : core.done) break;
    end
    core.req = 0;
    io.req = 0;
    @(posedge clk); #1;
  endtask
  initial begin
    int lat, csw, nd, prev, lat1, lat15, w1, w15;
    logic ok, ov;
    logic [3:0] order;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h3C;
    {core.req, core.rw, core.addr, core.wdata} = '0;
    {io.req, io.rw, io.addr, io.wdata} = '0;
    {c1.req, c1.rw, c1.addr, c1.wdata} = '0;
    {i1.req, i1.rw, i1.addr, i1.wdata} = '0;
    {c15.req, c15.rw, c15.addr, c15.wdata} = '0;
    {i15.req, i15.rw, i15.addr, i15.wdata} = '0;
    v[0] = '{1'b0, 1'b1, 8'h10, 8'h00, 8'h3C, 8'h00};
    v[1] = '{1'b1, 1'b0, 8'h7F, 8'hA5, 8'h3C, 8'h00};
    v[2] = '{1'b0, 1'b1, 8'h7F, 8'h00, 8'hA5, 8'h00};
    v[3] = '{1'b1, 1'b1, 8'h10, 8'h00, 8'hA5, 8'h3C};
    v[4] = '{1'b0, 1'b0, 8'h10, 8'h5A, 8'hA5, 8'h3C};
    v[5] = '{1'b1, 1'b1, 8'h10, 8'h00, 8'hA5, 8'h5A};
    #12;
    chk("reset_busy", busy, 0);
    chk("reset_outputs", {ram_cs, ram_rw, ram_addr, ram_data_in, core.gnt, io.gnt}, 0);
    chk("reset_rdata", {core.rdata, io.rdata}, 0);
    @(negedge clk) rst_n = 1;
    for (int k = 0; k < 6; k++) begin
      xact(v[k].port, v[k].rw, v[k].addr, v[k].wdata, lat, csw, ok);
      chk($sformatf("v%0d_latency", k), lat, 4);
      chk($sformatf("v%0d_cs_width", k), csw, 2);
      chk($sformatf("v%0d_gnt", k), ok, 1);
      chk($sformatf("v%0d_core_rdata", k), core.rdata, v[k].exp_core);
      chk($sformatf("v%0d_io_rdata", k), io.rdata, v[k].exp_io);
      chk($sformatf("v%0d_idle_busy", k), busy, 0);
    end
    chk("mem_7f", mem[8'h7F], 8'hA5);
    chk("mem_10", mem[8'h10], 8'h5A);
    // both ports hold req: last served was io, so core goes first
    @(negedge clk);
    core.req = 1; core.rw = 1; core.addr = 8'h7F;
    io.req = 1; io.rw = 1; io.addr = 8'h10;
    nd = 0; prev = 0; order = 4'h0; ov = 0;
    for (int t = 1; t <= 40 && nd < 4; t++) begin
      @(posedge clk); #1;
      if ((core.gnt && io.gnt) || (core.done && io.done)) ov = 1;
      if (core.done || io.done) begin
        order[nd] = io.done;
        if (nd > 0) chk("rr_interval", t - prev, 5);
        prev = t;
        nd++;
      end
    end
    core.req = 0; io.req = 0;
    chk("rr_count", nd, 4);
    chk("rr_order", order, 4'b1010);
    chk("rr_overlap", ov, 0);
    chk("rr_core_rdata", core.rdata, 8'hA5);
    chk("rr_io_rdata", io.rdata, 8'h5A);
    @(posedge clk); #1;
    chk("rr_idle", busy, 0);
    // req dropped during ACCESS must not abort the write
    @(negedge clk);
    core.req = 1; core.rw = 0; core.addr = 8'h20; core.wdata = 8'h77;
    nd = 0;
    for (int t = 1; t <= 12; t++) begin
      @(posedge clk); #1;
      if (t == 2) core.req = 0;
      if (core.done) nd++;
    end
    chk("drop_done_count", nd, 1);
    chk("drop_busy", busy, 0);
    chk("drop_mem", mem[8'h20], 8'h77);
    // asynchronous reset in the middle of ACCESS
    @(negedge clk);
    core.req = 1; core.rw = 1; core.addr = 8'h10;
    io.req = 1; io.rw = 1; io.addr = 8'h7F;
    repeat (2) @(posedge clk);
    #2;
    chk("pre_reset_cs", ram_cs, 1);
    rst_n = 0;
    #1;
    chk("areset_cs", ram_cs, 0);
    chk("areset_gnt", {core.gnt, io.gnt}, 0);
    chk("areset_busy", busy, 0);
    chk("areset_rdata", {core.rdata, io.rdata}, 0);
    chk("areset_addr", ram_addr, 0);
    nd = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (core.done || io.done) nd++;
    end
    chk("areset_no_done", nd, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    chk("post_reset_tie", {core.gnt, io.gnt}, 2'b10);
    nd = 0;
    for (int t = 0; t < 20 && !core.done; t++) begin @(posedge clk); #1; end
    if (core.done) nd = 1;
    core.req = 0; io.req = 0;
    chk("post_reset_done", nd, 1);
    chk("post_reset_rdata", core.rdata, 8'h5A);
    @(posedge clk); #1;
    // CS_CYCLES extremes, both instances run side by side
    @(negedge clk);
    c1.req = 1; c1.rw = 1; c1.addr = 8'h01;
    c15.req = 1; c15.rw = 1; c15.addr = 8'h02;
    w1 = 0; w15 = 0; lat1 = 0; lat15 = 0;
    for (int t = 1; t <= 25; t++) begin
      @(posedge clk); #1;
      if (cs1) w1++;
      if (cs15) w15++;
      if (c1.done && lat1 == 0) begin lat1 = t; c1.req = 0; end
      if (c15.done && lat15 == 0) begin lat15 = t; c15.req = 0; end
    end
    chk("cs1_width", w1, 1);
    chk("cs1_latency", lat1, 3);
    chk("cs1_rdata", c1.rdata, 8'hC3);
    chk("cs15_width", w15, 15);
    chk("cs15_latency", lat15, 17);
    chk("cs15_rdata", c15.rdata, 8'h9E);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and access sequencer for the shared `ram_storage` array. It sits between the `ram_storage` port and two requesters:
- the core datapath (the DIR/SP address path driven by the control unit);
- the I/O side (`in`/`out` staging).

It grants one requester at a time using round-robin priority. It then runs a fixed setup / chip-select / complete sequence on the RAM pins and returns read data with a one-cycle done pulse. The control unit no longer drives RAM `cs`/`rw`/`addr` directly or uses delay-based chip-select pulses.

## Interface
- CS_CYCLES, 2, cycles `ram_cs` is held high per access; legal range 1..15.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- core_req  in  1  core access request; held until `core_done`.
- core_rw  in  1  1 = read, 0 = write (same sense as RAMrd).
- core_addr  in  8  core RAM address.
- core_wdata  in  8  core write data.
- core_gnt  out  1  core owns the RAM; high from SETUP through DONE.
- core_done  out  1  one-cycle completion pulse.
- core_rdata  out  8  last read data for core; held until the next core read completes.
- io_req, io_rw, io_addr, io_wdata  in  1/1/8/8  I/O requester; same meaning as the core signals.
- io_gnt, io_done, io_rdata  out  1/1/8  I/O counterparts of the core outputs.
- ram_cs  out  1  RAM chip select.
- ram_rw  out  1  RAM read/write (1 = read).
- ram_addr  out  8  RAM address.
- ram_data_in  out  8  RAM write data.
- ram_data_out  in  8  RAM read data.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states and transitions:
  - IDLE: if any request is pending, go to SETUP.
  - SETUP: always go to ACCESS.
  - ACCESS: stay for CS_CYCLES cycles, then go to DONE.
  - DONE: always go to IDLE.
  - DONE never chains directly to SETUP.
- Arbitration is evaluated only in IDLE:
  - Only one request: that requester wins.
  - Both requests: the requester not served last wins.
  - The `last` register updates on entry to SETUP.
  - Reset value of `last` = I/O, so the core wins the first tie.
- On the IDLE→SETUP edge, the winner's rw, addr and wdata are latched into internal registers.
  - Requester inputs are ignored until the next IDLE.
  - Deasserting req mid-transaction does not abort the transaction.
- RAM pin behaviour per state:
  - SETUP: `ram_addr`/`ram_rw`/`ram_data_in` = latched values; `ram_cs` = 0.
  - ACCESS: same values, with `ram_cs` = 1.
  - DONE: `ram_cs` = 0; addr/rw/data still held.
  - IDLE: `ram_rw` = 0, `ram_addr` = 0, `ram_data_in` = 0.
- Reads: `ram_data_out` is sampled on the edge leaving the last ACCESS cycle into the granted port's rdata register.
  - The data is valid in DONE.
  - The other port's rdata register is untouched.
- Writes: the granted port's rdata register is unchanged.
- The granted port's done is high for exactly the DONE cycle. gnt and done are never high for both ports at once.
- Reset asserted at any time, including mid-access:
  - FSM goes to IDLE and `last` goes to I/O.
  - All outputs go to 0 immediately: `ram_cs`, `ram_rw`, `ram_addr`, `ram_data_in`, both gnt, both done, both rdata, `busy`.
  - An aborted access produces no done pulse.

## Timing
- Cycle 0 = first edge at which IDLE samples req high.
- Cycle 1: SETUP; gnt = 1.
- Cycles 2..CS_CYCLES+1: ACCESS; `ram_cs` = 1.
- Cycle CS_CYCLES+2: DONE; done = 1, rdata valid.
- Cycle CS_CYCLES+3: IDLE.
- Request-to-done latency = CS_CYCLES+2 cycles. Peak throughput = one access per CS_CYCLES+3 cycles.
- Requester contract:
  - Drop req, or present a new request, on the edge ending DONE.
  - A req still high in the following IDLE is treated as a new request.
- Address, rw and write data are stable from SETUP to DONE. `ram_cs` never rises or falls in the same cycle as an address change.

## Test plan
- Core read, CS_CYCLES=2, RAM preloaded 0x3C at 0x10; `core_req`=1, `core_rw`=1, `core_addr`=0x10 → gnt at cycle 1, `ram_cs` high cycles 2–3, `core_done` at cycle 4, `core_rdata`=0x3C, `io_rdata` stays 0.
- I/O write 0xA5 to 0x7F, then core read of 0x7F → RAM holds 0xA5; `core_rdata`=0xA5; `io_rdata` unchanged.
- Both ports request continuously with distinct addresses → grants alternate core, io, core, io; each done arrives CS_CYCLES+3 cycles after the previous one; no overlapping gnt.
- Core drops req during ACCESS → access still completes, `core_done` pulses once, then IDLE with `busy`=0.
- Reset asserted during ACCESS → `ram_cs`, gnt, `busy` and rdata all go to 0 without waiting for a clock edge; no done pulse; after release, the core wins the first tie.
- CS_CYCLES=1 and CS_CYCLES=15 → `ram_cs` width is exactly 1 and 15 cycles respectively; done latency is 3 and 17 cycles.
